// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pkg
// Brief    : 1080p raster constants and colour-bar table for the HDMI path.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  localparam int unsigned H_ACT_1080P   = 1920;
  localparam int unsigned V_ACT_1080P   = 1080;
  localparam int unsigned H_TOTAL_1080P = 2200;
  localparam int unsigned V_TOTAL_1080P = 1125;
  localparam int unsigned H_SYNC_1080P  = 44;
  localparam int unsigned NUM_BARS      = 8;

  // Channel enables as {R,G,B}; the full-scale value is applied at use.
  localparam logic [2:0] RGB_WHITE   = 3'b111;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_BLACK   = 3'b000;

  // Lowest k with x < (k+1)*bar_w; anything at or past 7*bar_w lands in bar 7.
  function automatic logic [2:0] bar_index(input int unsigned x, input int unsigned bar_w);
    logic [2:0] idx;
    idx = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if (x < (32'(k) + 32'd1) * bar_w) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    rgb = RGB_BLACK;
    case (idx)
      3'd0:    rgb = RGB_WHITE;
      3'd1:    rgb = RGB_YELLOW;
      3'd2:    rgb = RGB_CYAN;
      3'd3:    rgb = RGB_GREEN;
      3'd4:    rgb = RGB_MAGENTA;
      3'd5:    rgb = RGB_RED;
      3'd6:    rgb = RGB_BLUE;
      default: rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_pattern_vg_if.sv
`default_nettype none
// ============================================================================
// Module   : test_pattern_vg_if
// Brief    : Raster-in / pixel-out bundle between sync generator and HDMI Tx.
// Revision : 1.0 - initial release
// ============================================================================
interface test_pattern_vg_if #(
  parameter int COCLOR_DEPP = 8,
  parameter int X_BITS      = 12
);
  logic [X_BITS-1:0]      act_x;
  logic                   vs_in;
  logic                   hs_in;
  logic                   de_in;
  logic                   vs_out;
  logic                   hs_out;
  logic                   de_out;
  logic [COCLOR_DEPP-1:0] r_out;
  logic [COCLOR_DEPP-1:0] g_out;
  logic [COCLOR_DEPP-1:0] b_out;

  modport master (
    output act_x, vs_in, hs_in, de_in,
    input  vs_out, hs_out, de_out, r_out, g_out, b_out
  );

  modport slave (
    input  act_x, vs_in, hs_in, de_in,
    output vs_out, hs_out, de_out, r_out, g_out, b_out
  );
endinterface
`default_nettype wire

// File: rtl/test_pattern_vg.sv
`default_nettype none
// ============================================================================
// Module   : test_pattern_vg
// Brief    : Eight vertical colour bars, timing and RGB in one register stage.
// Revision : 1.0 - initial release
// ============================================================================
module test_pattern_vg
  import hdmi_pkg::*;
#(
  parameter int COCLOR_DEPP = 8,
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 12,
  parameter int H_ACT       = 1920,
  parameter int V_ACT       = 1080
) (
  input  wire logic           pix_clk,
  input  wire logic           rst,
  test_pattern_vg_if.slave    bus
);

  localparam int unsigned c_bar_w = 32'(H_ACT) / NUM_BARS;

  generate
    if (H_ACT < 8 || COCLOR_DEPP < 1 || COCLOR_DEPP > 16 || Y_BITS < 1 || V_ACT < 1) begin : g_param_check
      $error("test_pattern_vg: parameter out of range");
    end
  endgenerate

  logic [2:0]             w_onoff;
  logic                   r_vs;
  logic                   r_hs;
  logic                   r_de;
  logic [COCLOR_DEPP-1:0] r_r;
  logic [COCLOR_DEPP-1:0] r_g;
  logic [COCLOR_DEPP-1:0] r_b;

  // Blanking forces black; act_x is only meaningful while de_in is high.
  always_comb begin
    w_onoff = RGB_BLACK;
    if (bus.de_in) w_onoff = bar_rgb(bar_index(32'(bus.act_x), c_bar_w));
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_vs <= 1'b0;
      r_hs <= 1'b0;
      r_de <= 1'b0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_vs <= bus.vs_in;
      r_hs <= bus.hs_in;
      r_de <= bus.de_in;
      r_r  <= {COCLOR_DEPP{w_onoff[2]}};
      r_g  <= {COCLOR_DEPP{w_onoff[1]}};
      r_b  <= {COCLOR_DEPP{w_onoff[0]}};
    end
  end

  assign bus.vs_out = r_vs;
  assign bus.hs_out = r_hs;
  assign bus.de_out = r_de;
  assign bus.r_out  = r_r;
  assign bus.g_out  = r_g;
  assign bus.b_out  = r_b;

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_vg.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_pattern_vg
// Brief    : Directed checks of the colour-bar generator at 1080p and 10-bit/1000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_pattern_vg;

  logic pix_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 pix_clk = ~pix_clk;

  test_pattern_vg_if #(.COCLOR_DEPP(8),  .X_BITS(12)) bus0();
  test_pattern_vg_if #(.COCLOR_DEPP(10), .X_BITS(12)) bus1();

  test_pattern_vg #(.COCLOR_DEPP(8), .X_BITS(12), .Y_BITS(12), .H_ACT(1920), .V_ACT(1080)) u_dut0 (
    .pix_clk (pix_clk),
    .rst     (rst),
    .bus     (bus0)
  );

  test_pattern_vg #(.COCLOR_DEPP(10), .X_BITS(12), .Y_BITS(12), .H_ACT(1000), .V_ACT(600)) u_dut1 (
    .pix_clk (pix_clk),
    .rst     (rst),
    .bus     (bus1)
  );

  int total  = 0;
  int passed = 0;

  // Reference colour as {R,G,B}, 16 bits per channel, bar chosen by division.
  function automatic logic [47:0] exp_rgb(input int x, input logic de, input int bar_w, input int depth);
    logic [7:0]  r_tab;
    logic [7:0]  g_tab;
    logic [7:0]  b_tab;
    logic [15:0] maxv;
    int          bar;
    r_tab = 8'b0011_0011;
    g_tab = 8'b0000_1111;
    b_tab = 8'b0101_0101;
    maxv  = 16'((1 << depth) - 1);
    bar   = x / bar_w;
    if (bar > 7) bar = 7;
    if (!de) return 48'd0;
    return {(r_tab[bar] ? maxv : 16'd0), (g_tab[bar] ? maxv : 16'd0), (b_tab[bar] ? maxv : 16'd0)};
  endfunction

  function automatic logic [47:0] obs0();
    return {16'(bus0.r_out), 16'(bus0.g_out), 16'(bus0.b_out)};
  endfunction

  function automatic logic [47:0] obs1();
    return {16'(bus1.r_out), 16'(bus1.g_out), 16'(bus1.b_out)};
  endfunction

  task automatic chk(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs, input int x0, input int x1);
    bus0.de_in = de;  bus0.hs_in = hs;  bus0.vs_in = vs;  bus0.act_x = 12'(x0);
    bus1.de_in = de;  bus1.hs_in = hs;  bus1.vs_in = vs;  bus1.act_x = 12'(x1);
  endtask

  task automatic step(input logic de, input int x0, input int x1);
    drive(de, 1'b1, 1'b0, x0, x1);
    @(posedge pix_clk);
    #1;
  endtask

  int sync_err;
  int pix_err;
  logic de_r, hs_r, vs_r;

  initial begin
    drive(1'b1, 1'b0, 1'b1, 100, 100);
    #2;
    chk("reset_async_zero", {42'd0, bus0.vs_out, bus0.hs_out, bus0.de_out, bus1.de_out, 2'd0} | obs0(), 48'd0);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], ~i[0], i[0], 240 * i, 125 * i);
      @(posedge pix_clk);
      #1;
      chk("reset_held_zero", {45'd0, bus0.vs_out, bus0.hs_out, bus0.de_out} | obs0() | obs1(), 48'd0);
    end
    rst = 1'b0;

    step(1'b1, 0, 124);
    chk("first_white_de", {47'd0, bus0.de_out}, 48'd1);
    chk("first_white_rgb", obs0(), {16'hff, 16'hff, 16'hff});
    chk("d10_x124_white", obs1(), {16'h3ff, 16'h3ff, 16'h3ff});

    step(1'b1, 239, 125);
    chk("x239_white", obs0(), {16'hff, 16'hff, 16'hff});
    chk("d10_x125_yellow", obs1(), {16'h3ff, 16'h3ff, 16'h0});
    step(1'b1, 240, 875);
    chk("x240_yellow", obs0(), {16'hff, 16'hff, 16'h0});
    chk("d10_x875_black", obs1(), 48'd0);
    step(1'b1, 1199, 999);
    chk("x1199_magenta", obs0(), {16'hff, 16'h0, 16'hff});
    chk("d10_x999_black", obs1(), 48'd0);
    step(1'b1, 1200, 874);
    chk("x1200_red", obs0(), {16'hff, 16'h0, 16'h0});
    chk("d10_x874_blue", obs1(), {16'h0, 16'h0, 16'h3ff});
    step(1'b1, 1680, 0);
    chk("x1680_black", obs0(), 48'd0);
    step(1'b1, 1919, 0);
    chk("x1919_black", obs0(), 48'd0);
    step(1'b1, 4000, 4000);
    chk("x_beyond_black", obs0() | obs1(), 48'd0);
    step(1'b1, 720, 0);
    chk("x720_green", obs0(), {16'h0, 16'hff, 16'h0});
    step(1'b0, 300, 300);
    chk("blank_rgb", obs0() | obs1(), 48'd0);
    chk("blank_de", {47'd0, bus0.de_out}, 48'd0);

    // Mid-line asynchronous reset.
    step(1'b1, 500, 500);
    chk("x500_cyan", obs0(), {16'h0, 16'hff, 16'hff});
    #2 rst = 1'b1;
    #1;
    chk("midline_rst_rgb", obs0() | obs1(), 48'd0);
    chk("midline_rst_sync", {45'd0, bus0.vs_out, bus0.hs_out, bus0.de_out}, 48'd0);
    @(posedge pix_clk);
    #1 rst = 1'b0;
    step(1'b1, 500, 500);
    chk("resume_x500_cyan", obs0(), {16'h0, 16'hff, 16'hff});
    chk("resume_d10_x500_magenta", obs1(), {16'h3ff, 16'h0, 16'h3ff});

    // Three 2200-clock lines; active-low hsync, vsync high for line 1.
    sync_err = 0;
    pix_err  = 0;
    for (int line = 0; line < 3; line++) begin
      for (int h = 0; h < 2200; h++) begin
        de_r = (h < 1920);
        hs_r = !(h >= 2008 && h < 2052);
        vs_r = (line == 1);
        drive(de_r, hs_r, vs_r, de_r ? h : 0, de_r ? h % 1000 : 0);
        @(posedge pix_clk);
        #1;
        if (bus0.hs_out !== hs_r || bus0.vs_out !== vs_r || bus0.de_out !== de_r) sync_err++;
        if (obs0() !== exp_rgb(h, de_r, 240, 8)) pix_err++;
        if (line == 0 && h == 0)
          chk("raster_de_with_white", {47'd0, bus0.de_out} | obs0(), {16'hff, 16'hff, 16'hff});
      end
    end
    chk("raster_sync_shift", 48'(sync_err), 48'd0);
    chk("raster_pixels", 48'(pix_err), 48'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
